// File: rtl/neuro_pkg.sv
// Shared definitions for the neuron potential datapath: decay-rate codes,
// FP32 field layout and the sweep controller state encoding.
package neuro_pkg;

    localparam logic [3:0] RATE_DIV1 = 4'b0001;
    localparam logic [3:0] RATE_DIV2 = 4'b0010;
    localparam logic [3:0] RATE_DIV4 = 4'b0100;
    localparam logic [3:0] RATE_DIV8 = 4'b1000;
    localparam logic [3:0] RATE_3Q   = 4'b0011;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam logic [FP_EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/fp32_decay_scale.sv
// Combinational FP32 leak: divides by a power of two (exponent decrement) or
// scales by 0.75 (3 x significand, renormalised by at most one position).
// Results truncate toward zero; underflow flushes to a signed zero and
// Inf/NaN pass straight through.
module fp32_decay_scale
    import neuro_pkg::*;
(
    input  logic [31:0] pot_in,
    input  logic [3:0]  rate,
    output logic [31:0] pot_out
);

    logic                sgn;
    logic [FP_EXP_W-1:0] ex;
    logic [FP_MAN_W-1:0] man;
    logic [FP_EXP_W-1:0] shift;
    // 3 x {1,man} shifted right by one, i.e. bits [25:1] of the full product;
    // floor(3x/2) == x + floor(x/2), so the dropped LSB never carries.
    logic [24:0]         prod_hi;

    assign sgn = pot_in[31];
    assign ex  = pot_in[30:23];
    assign man = pot_in[22:0];

    // Pick the exponent decrement for the power-of-two codes; unknown codes leave the value untouched.
    always_comb begin
        shift = 8'd0;
        case (rate)
            RATE_DIV2: shift = 8'd1;
            RATE_DIV4: shift = 8'd2;
            RATE_DIV8: shift = 8'd3;
            default:   shift = 8'd0;
        endcase
    end

    // Decay result with special-value handling ahead of the arithmetic paths.
    always_comb begin
        prod_hi = {1'b0, 1'b1, man} + {2'b00, 1'b1, man[22:1]};
        pot_out = {sgn, 31'b0};
        if (ex == '0) begin
            pot_out = {sgn, 31'b0};
        end else if (ex == EXP_MAX) begin
            pot_out = pot_in;
        end else if (rate == RATE_3Q) begin
            if (prod_hi[24]) begin
                pot_out = {sgn, ex, prod_hi[23:1]};
            end else if (ex == 8'd1) begin
                pot_out = {sgn, 31'b0};
            end else begin
                pot_out = {sgn, ex - 8'd1, prod_hi[22:0]};
            end
        end else if (ex <= shift) begin
            pot_out = {sgn, 31'b0};
        end else begin
            pot_out = {sgn, ex - shift, man};
        end
    end

endmodule

// File: rtl/potential_decay_array.sv
// Register file of FP32 membrane potentials and decay codes. A start pulse
// sweeps every neuron once, one per cycle: read, decay, write back and stream
// the result to the threshold stage. Adder write-backs always win a same-
// address collision; init writes are only taken while the sweep is idle.
module potential_decay_array
    import neuro_pkg::*;
#(
    parameter  int NUM_NEURONS = 30,
    localparam int ADDR_W      = $clog2(NUM_NEURONS)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              init_valid,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [31:0]       init_potential,
    input  logic [3:0]        init_rate,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [31:0]       upd_potential,
    input  logic              start,
    output logic              busy,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_potential,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx_p0;
    logic [31:0]       pot_mem  [NUM_NEURONS];
    logic [3:0]        rate_mem [NUM_NEURONS];
    logic [31:0]       rd_pot_p0;
    logic [3:0]        rd_rate_p0;
    logic [31:0]       dec_pot_p0;
    logic              sweep_en;
    logic              init_ok;

    assign sweep_en   = (state == SWEEP);
    assign busy       = (state != IDLE);
    assign init_ok    = init_valid && !busy;

    // Stage p0: read the neuron under the sweep pointer and decay it.
    assign rd_pot_p0  = pot_mem[idx_p0];
    assign rd_rate_p0 = rate_mem[idx_p0];

    fp32_decay_scale u_decay (
        .pot_in  (rd_pot_p0),
        .rate    (rd_rate_p0),
        .pot_out (dec_pot_p0)
    );

    // Controller state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one SWEEP cycle per neuron, then a single FIN cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SWEEP;
            SWEEP:   if (idx_p0 == LAST_IDX) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sweep pointer: advances through the array, parked at zero otherwise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                              idx_p0 <= '0;
        else if (sweep_en && idx_p0 != LAST_IDX) idx_p0 <= idx_p0 + 1'b1;
        else                                     idx_p0 <= '0;
    end

    // Stage p1: register the streamed result and the end-of-sweep pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_potential <= '0;
            done          <= 1'b0;
        end else begin
            out_valid <= sweep_en;
            done      <= (state == FIN);
            if (sweep_en) begin
                out_addr      <= idx_p0;
                out_potential <= dec_pot_p0;
            end
        end
    end

    // Storage write port: adder update beats sweep write-back beats init.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_mem[i]  <= '0;
                rate_mem[i] <= RATE_DIV1;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (upd_valid && upd_addr == ADDR_W'(i)) begin
                    pot_mem[i] <= upd_potential;
                end else if (sweep_en && idx_p0 == ADDR_W'(i)) begin
                    pot_mem[i] <= dec_pot_p0;
                end else if (init_ok && init_addr == ADDR_W'(i)) begin
                    pot_mem[i] <= init_potential;
                end
                if (init_ok && init_addr == ADDR_W'(i)) begin
                    rate_mem[i] <= init_rate;
                end
            end
        end
    end

endmodule

// File: doc/potential_decay_array.md
Name: potential_decay_array

Overview:
- Time-multiplexed, clocked successor to the per-neuron combinational decay units.
- Holds the FP32 membrane potential and decay-rate code for NUM_NEURONS neurons in a register file.
- On each timestep start pulse it sweeps all neurons, one per cycle, writes back the decayed potential, and streams each result out.
- Sits between the potential adder (which writes updates) and the spike/threshold stage (which consumes the stream).

Parameters:
- NUM_NEURONS, 30, number of neurons held; must be ≥ 2.
- ADDR_W, $clog2(NUM_NEURONS), neuron address width; derived, never overridden.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- init_valid  in  1  write init_potential and init_rate to init_addr; accepted only when busy=0.
- init_addr  in  ADDR_W  neuron to initialise.
- init_potential  in  32  initial FP32 potential.
- init_rate  in  4  decay code: 0001 ÷1, 0010 ÷2, 0100 ÷4, 1000 ÷8, 0011 ×0.75.
- upd_valid  in  1  potential-adder write-back; accepted in any state.
- upd_addr  in  ADDR_W  neuron being updated.
- upd_potential  in  32  new FP32 potential.
- start  in  1  timestep pulse; begins a sweep; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- out_valid  out  1  out_addr and out_potential are valid this cycle.
- out_addr  out  ADDR_W  neuron address of the streamed result.
- out_potential  out  32  decayed FP32 potential.
- done  out  1  one-cycle pulse marking the end of a sweep.

Behaviour:
- Reset state: FSM IDLE; busy, out_valid, done = 0; out_addr = 0; out_potential = 0; all stored potentials = 0; all rates = 4'b0001.
- FSM states:
  - IDLE: start=1 → SWEEP with idx=0.
  - SWEEP: reads potential[idx], computes the decay combinationally, writes the result back and registers it onto the out_* ports; idx increments each cycle; after idx=NUM_NEURONS-1 → FIN.
  - FIN: done=1 for one cycle, then → IDLE.
- Timing: start at cycle T; busy=1 from T+1 through T+NUM_NEURONS+1; out_valid for neuron k at T+2+k; done at T+NUM_NEURONS+2.
- Decay arithmetic (s = sign, e = exponent, m = mantissa):
  - e = 0 (zero or denormal) → output {s, 31'b0}.
  - e = 255 (Inf/NaN) → input passed through unchanged.
  - Rates ÷2^n (n = 0..3): if e ≤ n → {s, 31'b0}; else {s, e-n, m}.
  - Rate 0011: p = 3 × {1,m} (26 bits).
    - If p[25]=1 → {s, e, p[24:2]}.
    - Else, if e = 1 → {s, 31'b0}; otherwise {s, e-1, p[23:1]}.
    - Truncate toward zero; no rounding.
  - Any other rate code is treated as 0001.
- Write priority to the same address in the same cycle: upd > sweep write-back > init.
  - The streamed output is still the decay of the value read that cycle.
- upd_valid to an address the sweep has already passed is not decayed until the next sweep.
- init_valid while busy=1 is dropped with no effect.
- Reset asserted mid-sweep: immediate return to the reset state, stored potentials cleared, no done pulse.

Decomposition:
- Shared package neuro_pkg:
  - Decay-rate localparams: RATE_DIV1/2/4/8, RATE_3Q.
  - FP32 field widths and constants: EXP_MAX=8'hFF.
  - FSM state encoding: IDLE, SWEEP, FIN.
- Sub-module fp32_decay_scale: purely combinational (in 32, rate 4 → out 32), implements the decay arithmetic above. It replaces the Addition_Subtraction instance used for the ×0.75 case.

Test Plan:
- Reset, init neuron 0 = 0x41DED852 with rate 0010, start → out_addr 0, out_potential 0x415ED852 at T+2; done at T+NUM_NEURONS+2; stored value is 0x415ED852.
- Same input through rates 0100, 1000, 0011, 0001 → 0x40DED852, 0x405ED852, 0x41A7223D, 0x41DED852 respectively.
- Boundary values: 0x00800000 rate 0010 → 0x00000000; 0x80800000 rate 0010 → 0x80000000; 0x7F800000 rate 1000 → 0x7F800000; 0x00000001 rate 0100 → 0x00000000.
- Collision: upd_valid to neuron 5 with 0x40000000 in the cycle the sweep reads neuron 5 → stream shows the decay of the old value; stored value is 0x40000000.
- start and init_valid while busy → ignored; exactly NUM_NEURONS out_valid pulses and a single done.
- RST_N low at mid-sweep idx=10 → out_valid=0, busy=0, no done; a subsequent start outputs 0x00000000 for all neurons.
